// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the multi-channel storage bank.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        MODE_LATCH  = 2'b00,
        MODE_EDGE   = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_SHIFT  = 2'b11
    } mode_t;

    // A single-channel bank still gets a 1-bit select so the port never collapses.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/latch_bank_word.sv
// One WIDTH-bit storage word of the bank: load, toggle or shift, in that priority.
module latch_bank_word #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             toggle,
    input  logic             shift,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] word,
    output logic             msb,
    output logic             will_change
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_word;

    generate
        if (WIDTH == 1) begin : g_narrow
            assign shifted = shift_in;
        end else begin : g_wide
            assign shifted = {word[WIDTH-2:0], shift_in};
        end
    endgenerate

    always_comb begin
        next_word = word;
        if (load) begin
            next_word = d;
        end else if (toggle) begin
            next_word = word ^ d;
        end else if (shift) begin
            next_word = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
        end else begin
            word <= next_word;
        end
    end

    // Lets the top flag a content change without keeping a shadow copy of the bank.
    assign will_change = (next_word != word);
    assign msb         = word[WIDTH-1];

endmodule

// File: rtl/latch_bank.sv
// Multi-channel storage bank with latch, edge-capture, toggle and shift-chain modes.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic [WIDTH-1:0]        d,
    input  logic                    ser_in,
    output logic [WIDTH-1:0]        q_sel,
    output logic [NUM_CH*WIDTH-1:0] q_all,
    output logic                    ser_out,
    output logic                    chg,
    output logic [CNT_W-1:0]        wr_cnt
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);

    mode_t            mode_e;
    logic             en_q;
    logic             ch_valid;
    logic             do_load;
    logic             do_toggle;
    logic             do_shift;
    logic             write_event;
    logic [WIDTH-1:0] stored_sel;
    logic [WIDTH-1:0] words       [NUM_CH];
    logic             msb         [NUM_CH];
    logic             chain_in    [NUM_CH];
    logic [NUM_CH-1:0] will_change;

    assign mode_e   = mode_t'(mode);
    assign ch_valid = ({1'b0, ch_sel} < CH_LIMIT);

    // LATCH and EDGE both load d; they differ only in how en qualifies the write.
    assign do_load   = ch_valid && en &&
                       ((mode_e == MODE_LATCH) || ((mode_e == MODE_EDGE) && !en_q));
    assign do_toggle = ch_valid && en && (mode_e == MODE_TOGGLE);
    assign do_shift  = en && (mode_e == MODE_SHIFT);
    assign write_event = do_load || do_toggle || do_shift;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_word
            if (k == 0) begin : g_head
                assign chain_in[k] = ser_in;
            end else begin : g_link
                assign chain_in[k] = msb[k-1];
            end

            latch_bank_word #(
                .WIDTH(WIDTH)
            ) u_word (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (do_load && (ch_sel == CH_W'(k))),
                .toggle     (do_toggle && (ch_sel == CH_W'(k))),
                .shift      (do_shift),
                .shift_in   (chain_in[k]),
                .d          (d),
                .word       (words[k]),
                .msb        (msb[k]),
                .will_change(will_change[k])
            );

            assign q_all[k*WIDTH +: WIDTH] = words[k];
        end
    endgenerate

    always_comb begin
        stored_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                stored_sel = words[i];
            end
        end
    end

    // Transparent bypass makes LATCH mode behave like a real latch with zero latency.
    assign q_sel = ((mode_e == MODE_LATCH) && en && ch_valid) ? d : stored_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            ser_out <= 1'b0;
            chg     <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            en_q <= en;
            chg  <= |will_change;
            if (do_shift) begin
                ser_out <= msb[NUM_CH-1];
            end
            if (write_event && (wr_cnt != {CNT_W{1'b1}})) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_bank.sv
// Directed self-checking bench for latch_bank, including 1-channel and 2-bit counter builds.
module tb_latch_bank;

    logic       clk;
    logic       rst_n;

    logic       en;
    logic [1:0] mode;
    logic       ch_sel;
    logic [3:0] d;
    logic       ser_in;
    logic [3:0] q_sel;
    logic [7:0] q_all;
    logic       ser_out;
    logic       chg;
    logic [7:0] wr_cnt;

    logic       one_en;
    logic [1:0] one_mode;
    logic       one_ch_sel;
    logic [3:0] one_d;
    logic [3:0] one_q_sel;
    logic [3:0] one_q_all;
    logic       one_ser_out;
    logic       one_chg;
    logic [7:0] one_wr_cnt;

    logic       sat_en;
    logic [1:0] sat_mode;
    logic       sat_ch_sel;
    logic [3:0] sat_d;
    logic [3:0] sat_q_sel;
    logic [7:0] sat_q_all;
    logic       sat_ser_out;
    logic       sat_chg;
    logic [1:0] sat_wr_cnt;

    int assert_count;
    int fail_count;

    latch_bank #(.WIDTH(4), .NUM_CH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ch_sel(ch_sel), .d(d),
        .ser_in(ser_in), .q_sel(q_sel), .q_all(q_all), .ser_out(ser_out),
        .chg(chg), .wr_cnt(wr_cnt)
    );

    latch_bank #(.WIDTH(4), .NUM_CH(1), .CNT_W(8)) dut_one (
        .clk(clk), .rst_n(rst_n), .en(one_en), .mode(one_mode), .ch_sel(one_ch_sel),
        .d(one_d), .ser_in(1'b0), .q_sel(one_q_sel), .q_all(one_q_all),
        .ser_out(one_ser_out), .chg(one_chg), .wr_cnt(one_wr_cnt)
    );

    latch_bank #(.WIDTH(4), .NUM_CH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(sat_en), .mode(sat_mode), .ch_sel(sat_ch_sel),
        .d(sat_d), .ser_in(1'b0), .q_sel(sat_q_sel), .q_all(sat_q_all),
        .ser_out(sat_ser_out), .chg(sat_chg), .wr_cnt(sat_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        assert_count++; if (q_all !== 8'h00) begin $display("[TB] FAIL reset_q_all: got %h expected %h", q_all, 8'h00); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd0) begin $display("[TB] FAIL reset_wr_cnt: got %0d expected %0d", wr_cnt, 0); fail_count++; end
        assert_count++; if (chg !== 1'b0) begin $display("[TB] FAIL reset_chg: got %b expected %b", chg, 1'b0); fail_count++; end
        assert_count++; if (ser_out !== 1'b0) begin $display("[TB] FAIL reset_ser_out: got %b expected %b", ser_out, 1'b0); fail_count++; end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_latch();
        mode = 2'b00; ch_sel = 1'b1; en = 1'b1; d = 4'hA;
        #1;
        assert_count++; if (q_sel !== 4'hA) begin $display("[TB] FAIL latch_transparent: got %h expected %h", q_sel, 4'hA); fail_count++; end
        assert_count++; if (q_all !== 8'h00) begin $display("[TB] FAIL latch_q_all_before_edge: got %h expected %h", q_all, 8'h00); fail_count++; end
        tick(1);
        assert_count++; if (q_all !== 8'hA0) begin $display("[TB] FAIL latch_q_all: got %h expected %h", q_all, 8'hA0); fail_count++; end
        assert_count++; if (chg !== 1'b1) begin $display("[TB] FAIL latch_chg: got %b expected %b", chg, 1'b1); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd1) begin $display("[TB] FAIL latch_wr_cnt: got %0d expected %0d", wr_cnt, 1); fail_count++; end
        en = 1'b0; d = 4'h3;
        #1;
        assert_count++; if (q_sel !== 4'hA) begin $display("[TB] FAIL latch_hold: got %h expected %h", q_sel, 4'hA); fail_count++; end
        tick(1);
        assert_count++; if (q_all !== 8'hA0) begin $display("[TB] FAIL latch_hold_q_all: got %h expected %h", q_all, 8'hA0); fail_count++; end
        assert_count++; if (chg !== 1'b0) begin $display("[TB] FAIL latch_hold_chg: got %b expected %b", chg, 1'b0); fail_count++; end
    endtask

    task automatic test_edge();
        mode = 2'b01; ch_sel = 1'b0; d = 4'h5; en = 1'b1;
        tick(1);
        assert_count++; if (q_all !== 8'hA5) begin $display("[TB] FAIL edge_capture: got %h expected %h", q_all, 8'hA5); fail_count++; end
        d = 4'h6;
        tick(3);
        assert_count++; if (q_all !== 8'hA5) begin $display("[TB] FAIL edge_single_capture: got %h expected %h", q_all, 8'hA5); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd2) begin $display("[TB] FAIL edge_wr_cnt: got %0d expected %0d", wr_cnt, 2); fail_count++; end
        assert_count++; if (q_sel !== 4'h5) begin $display("[TB] FAIL edge_q_sel: got %h expected %h", q_sel, 4'h5); fail_count++; end
        // Toggle with zero mask keeps en high without changing data, then re-enter EDGE.
        mode = 2'b10; d = 4'h0;
        tick(1);
        assert_count++; if (wr_cnt !== 8'd3) begin $display("[TB] FAIL toggle_zero_wr_cnt: got %0d expected %0d", wr_cnt, 3); fail_count++; end
        mode = 2'b01; d = 4'hC;
        tick(1);
        assert_count++; if (q_all !== 8'hA5) begin $display("[TB] FAIL edge_enter_high: got %h expected %h", q_all, 8'hA5); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd3) begin $display("[TB] FAIL edge_enter_high_cnt: got %0d expected %0d", wr_cnt, 3); fail_count++; end
    endtask

    task automatic test_toggle();
        mode = 2'b10; ch_sel = 1'b0; d = 4'hF; en = 1'b1;
        tick(1);
        assert_count++; if (q_all !== 8'hAA) begin $display("[TB] FAIL toggle_first: got %h expected %h", q_all, 8'hAA); fail_count++; end
        assert_count++; if (chg !== 1'b1) begin $display("[TB] FAIL toggle_chg: got %b expected %b", chg, 1'b1); fail_count++; end
        tick(1);
        assert_count++; if (q_all !== 8'hA5) begin $display("[TB] FAIL toggle_second: got %h expected %h", q_all, 8'hA5); fail_count++; end
        d = 4'h0;
        tick(1);
        assert_count++; if (chg !== 1'b0) begin $display("[TB] FAIL toggle_zero_chg: got %b expected %b", chg, 1'b0); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd6) begin $display("[TB] FAIL toggle_zero_cnt: got %0d expected %0d", wr_cnt, 6); fail_count++; end
        assert_count++; if (q_all !== 8'hA5) begin $display("[TB] FAIL toggle_zero_data: got %h expected %h", q_all, 8'hA5); fail_count++; end
    endtask

    task automatic test_shift();
        mode = 2'b00; en = 1'b1; ch_sel = 1'b1; d = 4'h8;
        tick(1);
        ch_sel = 1'b0; d = 4'h0;
        tick(1);
        assert_count++; if (q_all !== 8'h80) begin $display("[TB] FAIL shift_setup: got %h expected %h", q_all, 8'h80); fail_count++; end
        mode = 2'b11; ser_in = 1'b1; ch_sel = 1'b1;
        tick(1);
        assert_count++; if (q_all !== 8'h01) begin $display("[TB] FAIL shift_first: got %h expected %h", q_all, 8'h01); fail_count++; end
        assert_count++; if (ser_out !== 1'b1) begin $display("[TB] FAIL shift_ser_out: got %b expected %b", ser_out, 1'b1); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd9) begin $display("[TB] FAIL shift_wr_cnt: got %0d expected %0d", wr_cnt, 9); fail_count++; end
        ser_in = 1'b0;
        tick(1);
        assert_count++; if (q_all !== 8'h02) begin $display("[TB] FAIL shift_walk: got %h expected %h", q_all, 8'h02); fail_count++; end
        assert_count++; if (ser_out !== 1'b0) begin $display("[TB] FAIL shift_ser_out_low: got %b expected %b", ser_out, 1'b0); fail_count++; end
        tick(7);
        assert_count++; if (q_all !== 8'h00) begin $display("[TB] FAIL shift_flush: got %h expected %h", q_all, 8'h00); fail_count++; end
        assert_count++; if (ser_out !== 1'b1) begin $display("[TB] FAIL shift_out_msb: got %b expected %b", ser_out, 1'b1); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd17) begin $display("[TB] FAIL shift_flush_cnt: got %0d expected %0d", wr_cnt, 17); fail_count++; end
        en = 1'b0;
        tick(2);
        assert_count++; if (ser_out !== 1'b1) begin $display("[TB] FAIL shift_out_hold: got %b expected %b", ser_out, 1'b1); fail_count++; end
    endtask

    task automatic test_reset_mid_shift();
        mode = 2'b11; ser_in = 1'b1; en = 1'b1;
        tick(9);
        assert_count++; if (q_all !== 8'hFF) begin $display("[TB] FAIL mid_shift_fill: got %h expected %h", q_all, 8'hFF); fail_count++; end
        rst_n = 1'b0;
        tick(1);
        assert_count++; if (q_all !== 8'h00) begin $display("[TB] FAIL mid_reset_q_all: got %h expected %h", q_all, 8'h00); fail_count++; end
        assert_count++; if (ser_out !== 1'b0) begin $display("[TB] FAIL mid_reset_ser_out: got %b expected %b", ser_out, 1'b0); fail_count++; end
        assert_count++; if (chg !== 1'b0) begin $display("[TB] FAIL mid_reset_chg: got %b expected %b", chg, 1'b0); fail_count++; end
        assert_count++; if (wr_cnt !== 8'd0) begin $display("[TB] FAIL mid_reset_wr_cnt: got %0d expected %0d", wr_cnt, 0); fail_count++; end
        assert_count++; if (q_sel !== 4'h0) begin $display("[TB] FAIL mid_reset_q_sel: got %h expected %h", q_sel, 4'h0); fail_count++; end
        en = 1'b0; rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_bad_channel();
        one_mode = 2'b00; one_ch_sel = 1'b1; one_en = 1'b1; one_d = 4'hF;
        #1;
        assert_count++; if (one_q_sel !== 4'h0) begin $display("[TB] FAIL bad_ch_q_sel: got %h expected %h", one_q_sel, 4'h0); fail_count++; end
        tick(1);
        assert_count++; if (one_q_all !== 4'h0) begin $display("[TB] FAIL bad_ch_no_write: got %h expected %h", one_q_all, 4'h0); fail_count++; end
        assert_count++; if (one_wr_cnt !== 8'd0) begin $display("[TB] FAIL bad_ch_wr_cnt: got %0d expected %0d", one_wr_cnt, 0); fail_count++; end
        assert_count++; if (one_chg !== 1'b0) begin $display("[TB] FAIL bad_ch_chg: got %b expected %b", one_chg, 1'b0); fail_count++; end
        one_ch_sel = 1'b0;
        tick(1);
        assert_count++; if (one_q_all !== 4'hF) begin $display("[TB] FAIL good_ch_write: got %h expected %h", one_q_all, 4'hF); fail_count++; end
        assert_count++; if (one_wr_cnt !== 8'd1) begin $display("[TB] FAIL good_ch_wr_cnt: got %0d expected %0d", one_wr_cnt, 1); fail_count++; end
        one_en = 1'b0;
    endtask

    task automatic test_saturate();
        sat_mode = 2'b10; sat_ch_sel = 1'b0; sat_d = 4'h1; sat_en = 1'b1;
        tick(3);
        assert_count++; if (sat_wr_cnt !== 2'd3) begin $display("[TB] FAIL sat_reach: got %0d expected %0d", sat_wr_cnt, 3); fail_count++; end
        tick(2);
        assert_count++; if (sat_wr_cnt !== 2'd3) begin $display("[TB] FAIL sat_hold: got %0d expected %0d", sat_wr_cnt, 3); fail_count++; end
        assert_count++; if (sat_q_all !== 8'h01) begin $display("[TB] FAIL sat_data: got %h expected %h", sat_q_all, 8'h01); fail_count++; end
        sat_en = 1'b0;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; ch_sel = 1'b0; d = 4'h0; ser_in = 1'b0;
        one_en = 1'b0; one_mode = 2'b00; one_ch_sel = 1'b0; one_d = 4'h0;
        sat_en = 1'b0; sat_mode = 2'b00; sat_ch_sel = 1'b0; sat_d = 4'h0;
        $display("[TB] starting latch_bank directed tests");
        test_reset();
        test_latch();
        test_edge();
        test_toggle();
        test_shift();
        test_reset_mid_shift();
        test_bad_channel();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
